// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types, opcodes and operand-usage decode for the IF/ID controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Opcodes whose rs1 field names a real source operand
    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    // Opcodes whose rs2 field names a real source operand
    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/if_id_ctrl_if.sv
// rtl/if_id_ctrl_if.sv - pipeline-side signal bundle of the IF/ID controller
interface if_id_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             MemRead_EX;
    logic [4:0]       RD_EX;
    logic [4:0]       RS1_ID;
    logic [4:0]       RS2_ID;
    logic [6:0]       OPCODE_ID;
    logic             branch_taken_EX;
    logic             hold_req;
    logic             counters_clr;
    logic             PC_write;
    logic             IF_ID_write;
    logic             PCSrc;
    logic             IF_ID_flush;
    logic             ID_EX_bubble;
    logic             hold_ack;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    // Pipeline / requester side
    modport master (
        output MemRead_EX, RD_EX, RS1_ID, RS2_ID, OPCODE_ID,
               branch_taken_EX, hold_req, counters_clr,
        input  PC_write, IF_ID_write, PCSrc, IF_ID_flush, ID_EX_bubble,
               hold_ack, stall_cycles, flush_count
    );

    // Controller side
    modport slave (
        input  MemRead_EX, RD_EX, RS1_ID, RS2_ID, OPCODE_ID,
               branch_taken_EX, hold_req, counters_clr,
        output PC_write, IF_ID_write, PCSrc, IF_ID_flush, ID_EX_bubble,
               hold_ack, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection between EX and ID
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       MemRead_EX,
    input  logic [4:0] RD_EX,
    input  logic [4:0] RS1_ID,
    input  logic [4:0] RS2_ID,
    input  logic [6:0] OPCODE_ID,
    output logic       load_use
);
    logic rs1_hit;
    logic rs2_hit;

    // x0 is never written, so a load targeting it cannot create a hazard
    assign rs1_hit  = (RD_EX == RS1_ID) && uses_rs1(OPCODE_ID);
    assign rs2_hit  = (RD_EX == RS2_ID) && uses_rs2(OPCODE_ID);
    assign load_use = MemRead_EX && (RD_EX != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/if_id_ctrl.sv
// rtl/if_id_ctrl.sv - IF/ID pipeline controller: boot window, stalls, flushes, hold handshake, perf counters
module if_id_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic      clk,
    input  logic      reset,
    if_id_ctrl_if.slave bus
);
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       boot_cnt;
    logic             load_use;
    logic             pc_write;
    logic             if_id_write;
    logic             pc_src;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             hold_ack_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             stall_inc;
    logic             flush_inc;

    hazard_detect u_hazard (
        .MemRead_EX (bus.MemRead_EX),
        .RD_EX      (bus.RD_EX),
        .RS1_ID     (bus.RS1_ID),
        .RS2_ID     (bus.RS2_ID),
        .OPCODE_ID  (bus.OPCODE_ID),
        .load_use   (load_use)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // Boot window counter, runs only while in BOOT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                boot_cnt <= 4'd0;
        else if (state_q == BOOT)  boot_cnt <= boot_cnt + 4'd1;
        else                       boot_cnt <= 4'd0;
    end

    // Next state: branch and load-use both defer hold entry by a cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: if (boot_cnt == BOOT_LAST) state_d = RUN;
            RUN: begin
                if (!bus.branch_taken_EX && !load_use && bus.hold_req) state_d = HOLD;
            end
            HOLD: if (!bus.hold_req) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Control outputs from state and current inputs
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        pc_src       = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        case (state_q)
            BOOT: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            RUN: begin
                if (bus.branch_taken_EX) begin
                    pc_src       = 1'b1;
                    pc_write     = 1'b1;
                    if_id_write  = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    id_ex_bubble = 1'b1;
                end else begin
                    pc_write     = 1'b1;
                    if_id_write  = 1'b1;
                end
            end
            HOLD: id_ex_bubble = 1'b1;
            default: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        endcase
    end

    // Acknowledge lags HOLD entry by one edge so the requester sees a settled freeze
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hold_ack_q <= 1'b0;
        else        hold_ack_q <= (state_q == HOLD);
    end

    assign stall_inc = (state_q != BOOT) && !if_id_write;
    assign flush_inc = (state_q == RUN) && bus.branch_taken_EX;

    // Saturating stall counter; clear beats increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          stall_q <= '0;
        else if (bus.counters_clr)           stall_q <= '0;
        else if (stall_inc && stall_q != '1) stall_q <= stall_q + 1'b1;
    end

    // Saturating branch-flush counter; clear beats increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          flush_q <= '0;
        else if (bus.counters_clr)           flush_q <= '0;
        else if (flush_inc && flush_q != '1) flush_q <= flush_q + 1'b1;
    end

    assign bus.PC_write     = pc_write;
    assign bus.IF_ID_write  = if_id_write;
    assign bus.PCSrc        = pc_src;
    assign bus.IF_ID_flush  = if_id_flush;
    assign bus.ID_EX_bubble = id_ex_bubble;
    assign bus.hold_ack     = hold_ack_q;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;
endmodule

// File: tb/tb_if_id_ctrl.sv
// tb/tb_if_id_ctrl.sv - directed self-checking bench for if_id_ctrl
module tb_if_id_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic hs;

    if_id_ctrl_if #(.CNT_W(16)) bus ();

    if_id_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic pcw, input logic ifw,
                           input logic psrc, input logic fl, input logic bub);
        chk1({tag, "/PC_write"},     bus.PC_write,     pcw);
        chk1({tag, "/IF_ID_write"},  bus.IF_ID_write,  ifw);
        chk1({tag, "/PCSrc"},        bus.PCSrc,        psrc);
        chk1({tag, "/IF_ID_flush"},  bus.IF_ID_flush,  fl);
        chk1({tag, "/ID_EX_bubble"}, bus.ID_EX_bubble, bub);
    endtask

    task automatic idle();
        bus.MemRead_EX      = 1'b0;
        bus.RD_EX           = 5'd0;
        bus.RS1_ID          = 5'd0;
        bus.RS2_ID          = 5'd0;
        bus.OPCODE_ID       = 7'd0;
        bus.branch_taken_EX = 1'b0;
        bus.hold_req        = 1'b0;
        bus.counters_clr    = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #2;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk1("reset/hold_ack", bus.hold_ack, 1'b0);
        chkn("reset/stall", bus.stall_cycles, 16'd0);
        chkn("reset/flush", bus.flush_count, 16'd0);

        reset = 1'b1;
        #1;
        chk_out("boot0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(); #1;
        chk_out("boot1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(); #1;
        chk_out("run0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chkn("run0/stall", bus.stall_cycles, 16'd0);
        chkn("run0/flush", bus.flush_count, 16'd0);

        // load-use on rs2 of an R-type
        cyc();
        bus.MemRead_EX = 1'b1; bus.RD_EX = 5'd5; bus.RS2_ID = 5'd5; bus.OPCODE_ID = 7'b0110011;
        #1;
        chk_out("lu", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(); idle(); #1;
        chk_out("lu_rel", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chkn("lu/stall", bus.stall_cycles, 16'd1);
        // load to x0 never stalls
        bus.MemRead_EX = 1'b1; bus.RD_EX = 5'd0; bus.RS2_ID = 5'd0; bus.OPCODE_ID = 7'b0110011;
        #1;
        chk1("lu_x0/PC_write", bus.PC_write, 1'b1);
        // I-type ignores its rs2 field
        cyc();
        bus.MemRead_EX = 1'b1; bus.RD_EX = 5'd5; bus.RS2_ID = 5'd5; bus.OPCODE_ID = 7'b0010011;
        #1;
        chk1("lu_itype/PC_write", bus.PC_write, 1'b1);
        chk1("lu_itype/ID_EX_bubble", bus.ID_EX_bubble, 1'b0);
        // load consuming rs1 does stall
        cyc();
        bus.MemRead_EX = 1'b1; bus.RD_EX = 5'd7; bus.RS1_ID = 5'd7; bus.RS2_ID = 5'd0;
        bus.OPCODE_ID = 7'b0000011;
        #1;
        chk1("lu_rs1/PC_write", bus.PC_write, 1'b0);
        cyc(); idle(); #1;
        chkn("lu_rs1/stall", bus.stall_cycles, 16'd2);

        // branch flush, then branch together with load-use
        cyc();
        bus.branch_taken_EX = 1'b1;
        #1;
        chk_out("br", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(); idle(); #1;
        chkn("br/flush", bus.flush_count, 16'd1);
        cyc();
        bus.branch_taken_EX = 1'b1;
        bus.MemRead_EX = 1'b1; bus.RD_EX = 5'd5; bus.RS2_ID = 5'd5; bus.OPCODE_ID = 7'b0110011;
        #1;
        chk_out("br_lu", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(); idle(); #1;
        chkn("br_lu/flush", bus.flush_count, 16'd2);
        chkn("br_lu/stall", bus.stall_cycles, 16'd2);

        // hold request at k=0, released at k=10; branch at k=5 is ignored
        for (int k = 0; k <= 12; k++) begin
            cyc();
            bus.hold_req        = (k < 10);
            bus.branch_taken_EX = (k == 5);
            #1;
            hs = (k >= 1) && (k <= 10);
            chk1($sformatf("hold%0d/PC_write", k), bus.PC_write, !hs);
            chk1($sformatf("hold%0d/hold_ack", k), bus.hold_ack, (k >= 2) && (k <= 11));
            if (k == 5) chk1("hold5/PCSrc", bus.PCSrc, 1'b0);
        end
        cyc(); idle(); #1;
        chkn("hold/stall", bus.stall_cycles, 16'd12);
        chkn("hold/flush", bus.flush_count, 16'd2);

        // hold request colliding with a branch slips one cycle
        for (int k = 0; k <= 5; k++) begin
            cyc();
            bus.hold_req        = (k <= 3);
            bus.branch_taken_EX = (k == 0);
            #1;
            hs = (k >= 2) && (k <= 4);
            chk1($sformatf("hold_br%0d/PC_write", k), bus.PC_write, !hs);
        end
        cyc(); idle(); #1;
        chkn("hold_br/flush", bus.flush_count, 16'd3);
        chkn("hold_br/stall", bus.stall_cycles, 16'd15);

        // saturation, then clear
        cyc();
        bus.hold_req = 1'b1;
        repeat (70000) cyc();
        #1;
        chkn("sat/stall", bus.stall_cycles, 16'hFFFF);
        chk1("sat/hold_ack", bus.hold_ack, 1'b1);
        bus.counters_clr = 1'b1;
        cyc();
        bus.counters_clr = 1'b0;
        #1;
        chkn("clr/stall", bus.stall_cycles, 16'd0);
        chkn("clr/flush", bus.flush_count, 16'd0);
        cyc(); #1;
        chkn("clr_next/stall", bus.stall_cycles, 16'd1);

        // asynchronous reset while in HOLD
        reset = 1'b0;
        #1;
        chk1("arst/hold_ack", bus.hold_ack, 1'b0);
        chk_out("arst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chkn("arst/stall", bus.stall_cycles, 16'd0);
        idle();
        reset = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_id_ctrl.md
# if_id_ctrl

Pipeline controller for the IF/ID front end. It sequences the PC and IF/ID pipeline register through:
- a post-reset boot window,
- load-use stalls,
- taken-branch flushes,
- an external hold handshake.

It drives PC_write, IF_ID_write, PCSrc and the IF/ID flush, plus a bubble into ID/EX. It also keeps saturating stall and flush counters for performance monitoring.

## Interface
- BOOT_CYCLES, 2, cycles after reset release during which fetch is frozen and IF/ID is flushed; legal range 1..15
- CNT_W, 16, width of the performance counters
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- MemRead_EX  in  1  instruction in EX is a load
- RD_EX  in  5  destination register of the instruction in EX
- RS1_ID, RS2_ID  in  5 each  source registers of the instruction in ID
- OPCODE_ID  in  7  opcode of the instruction in ID
- branch_taken_EX  in  1  branch/jump in EX resolved taken this cycle
- hold_req  in  1  external request to freeze the front end (level)
- counters_clr  in  1  synchronous clear of both counters
- PC_write  out  1  PC load enable
- IF_ID_write  out  1  IF/ID load enable
- PCSrc  out  1  selects PC_Branch into the PC
- IF_ID_flush  out  1  synchronous zeroing of IF/ID (wired to its reset input)
- ID_EX_bubble  out  1  force ID/EX control fields to zero
- hold_ack  out  1  front end frozen for requester
- stall_cycles  out  CNT_W  saturating count of stalled cycles
- flush_count  out  CNT_W  saturating count of branch flushes

## Operation
- The state machine has three states: BOOT, RUN, HOLD. The state is registered; all outputs except hold_ack and the counters are combinational from the state and the current inputs.
- **BOOT**
  - Outputs: PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_bubble=1, PCSrc=0.
  - boot_cnt counts 0..BOOT_CYCLES-1. The state moves to RUN on the edge where boot_cnt==BOOT_CYCLES-1.
- **RUN**, evaluated in priority order:
  1. branch_taken_EX=1: PCSrc=1, PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1. flush_count increments. Any hold entry is deferred.
  2. load_use=1: PC_write=0, IF_ID_write=0, ID_EX_bubble=1. Hold entry is deferred.
  3. hold_req=1: normal advance this cycle; the state moves to HOLD at the next edge.
  4. Otherwise: PC_write=1, IF_ID_write=1, all other control outputs 0.
- **load_use** is asserted when all of the following hold:
  - MemRead_EX=1 and RD_EX≠0;
  - (RD_EX==RS1_ID and uses_rs1) or (RD_EX==RS2_ID and uses_rs2).
- **Source-register usage by opcode:**
  - uses_rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2: 0110011, 0100011, 1100011.
- **HOLD**
  - Outputs: PC_write=0, IF_ID_write=0, ID_EX_bubble=1, PCSrc=0, IF_ID_flush=0. branch_taken_EX is ignored (EX holds bubbles).
  - The state returns to RUN at the first edge with hold_req=0.
- **hold_ack** is registered: hold_ack = (state==HOLD).
- **stall_cycles** increments in each RUN or HOLD cycle with IF_ID_write=0. BOOT cycles are not counted.
- **Counter rules:**
  - Both counters saturate at all-ones.
  - counters_clr has priority over increment; the cleared value is visible the next cycle.

## Timing
- **Reset asserted (reset=0):**
  - state=BOOT, boot_cnt=0, hold_ack=0, counters=0.
  - PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_bubble=1, PCSrc=0.
- **After reset release:** exactly BOOT_CYCLES cycles of BOOT, then the first RUN cycle with PC_write=1.
- **Load-use:** a single stall cycle. The bubble clears MemRead_EX the next cycle, so release is automatic.
- **Branch flush:** zero stall. The flush and redirect happen in the same cycle as branch_taken_EX.
- **Hold handshake:**
  - Request at cycle n (no conflicts) gives HOLD from n+1 and hold_ack=1 from n+2.
  - Release at cycle m gives RUN at m+1 and hold_ack=0 at m+2.
  - The requester must keep hold_req high until it sees hold_ack.
- **Simultaneous events:**
  - Branch together with load_use: the branch wins.
  - Branch or load_use together with hold_req: hold entry slips one cycle per conflict.
- **Reset mid-HOLD or mid-stall:** immediate return to BOOT; hold_ack drops asynchronously.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum {BOOT, RUN, HOLD};
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR.
- Sub-module hazard_detect is purely combinational. It takes MemRead_EX, RD_EX, RS1_ID, RS2_ID, OPCODE_ID and produces load_use.
- The FSM and counters live in if_id_ctrl.

## Test plan
- **Reset and boot:** release reset with BOOT_CYCLES=2. Required: PC_write=0 and IF_ID_flush=1 for 2 cycles, then PC_write=1, IF_ID_write=1, all counters 0.
- **Load-use:** MemRead_EX=1, RD_EX=5, RS2_ID=5, OPCODE_ID=0110011. Required: one cycle of PC_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_cycles=1. Repeat with RD_EX=0 or OPCODE_ID=0010011 on the rs2 match: no stall.
- **Branch flush:** branch_taken_EX=1 pulse. Required: PCSrc=1, PC_write=1, IF_ID_flush=1, ID_EX_bubble=1 for that cycle; flush_count=1. With load_use also true in the same cycle: identical response.
- **Hold handshake:** hold_req high at cycle 10, low at 20. Required: hold_ack=1 during cycles 12..21, PC_write=0 during cycles 11..20, stall_cycles=10. With branch_taken_EX at cycle 10: HOLD entry at cycle 12 instead.
- **Saturation and clear:** force 70000 stall cycles with CNT_W=16. Required: stall_cycles=0xFFFF. Then counters_clr for 1 cycle: required value 0 the next cycle.
- **Async reset in HOLD:** reset=0 mid-HOLD. Required: hold_ack=0 and state=BOOT without waiting for a clock edge.
